hazard_forward_controller: RTL and testbench

//  Sequences the ARM-style 5-stage pipeline around EXE: ALU operand forwarding selects (00 reg, 01 MEM, 10 WB),

---
 rtl/hazard_forward_controller_pkg.sv | 22 ++
 rtl/hazard_forward_controller_fwd_select.sv | 32 +++
 rtl/hazard_forward_controller.sv | 166 ++++++++++++++++
 tb/tb_hazard_forward_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_forward_controller_pkg.sv
// rtl/hazard_forward_controller_pkg.sv - shared encodings for the hazard/forwarding controller
package hazard_forward_controller_pkg;

  localparam int REG_W = 4;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_BR_FLUSH = 2'b01,
    ST_MEM_WAIT = 2'b10
  } state_e;

  // True when a valid source register matches an enabled destination.
  function automatic logic reg_hit(input logic [REG_W-1:0] src, input logic src_valid,
                                   input logic [REG_W-1:0] dst, input logic dst_en);
    return src_valid && dst_en && (src == dst);
  endfunction

endpackage

// File: rtl/hazard_forward_controller_fwd_select.sv
// rtl/hazard_forward_controller_fwd_select.sv - forwarding mux select for one EXE operand
module fwd_select
  import hazard_forward_controller_pkg::*;
(
  input  logic             forward_en,
  input  logic [REG_W-1:0] src,
  input  logic             src_valid,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_wb_en,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_wb_en,
  output logic [1:0]       sel
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = reg_hit(src, src_valid, mem_dst, mem_wb_en);
  assign wb_hit  = reg_hit(src, src_valid, wb_dst, wb_wb_en);

  // MEM holds the younger result, so it wins over WB.
  always_comb begin
    sel = FWD_REG;
    if (forward_en) begin
      if (mem_hit)
        sel = FWD_MEM;
      else if (wb_hit)
        sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_controller.sv
// rtl/hazard_forward_controller.sv - stall/flush/freeze sequencing and operand forwarding around EXE
module hazard_forward_controller
  import hazard_forward_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             forward_en,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_uses_rn,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] exe_dst,
  input  logic             exe_wb_en,
  input  logic             exe_mem_read,
  input  logic             exe_b,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_wb_en,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_wb_en,
  output logic             stall_if,
  output logic             stall_id,
  output logic             flush_if,
  output logic             bubble_id,
  output logic             freeze_all,
  output logic [1:0]       sel_src1,
  output logic [1:0]       sel_src2,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_e           state;
  state_e           ret_state;
  state_e           eff_state;
  logic [FC_W-1:0]  fcnt;
  logic [WC_W-1:0]  wait_cnt;
  logic [REG_W-1:0] exe_src1;
  logic [REG_W-1:0] exe_src2;
  logic             exe_src1_valid;
  logic             exe_src2_valid;
  logic             flush;
  logic             hazard;
  logic             raw_src1;
  logic             raw_src2;

  function automatic logic raw_hit(input logic [REG_W-1:0] src, input logic valid);
    if (forward_en)
      return exe_mem_read && reg_hit(src, valid, exe_dst, exe_wb_en);
    return reg_hit(src, valid, exe_dst, exe_wb_en) || reg_hit(src, valid, mem_dst, mem_wb_en);
  endfunction

  assign raw_src1 = raw_hit(id_src1, id_uses_rn);
  assign raw_src2 = raw_hit(id_src2, id_two_src);

  // The cycle freeze drops while still in MEM_WAIT is a live pipeline cycle,
  // so it behaves as the state that was interrupted.
  always_comb begin
    freeze_all = mem_access & ~mem_ready;
    eff_state  = (state == ST_MEM_WAIT) ? ret_state : state;
    flush      = ~freeze_all & (((eff_state == ST_RUN) & exe_b) | (eff_state == ST_BR_FLUSH));
    hazard     = ~freeze_all & (eff_state == ST_RUN) & ~exe_b & (raw_src1 | raw_src2);
    stall_if   = freeze_all | hazard;
    stall_id   = freeze_all | hazard;
    flush_if   = flush;
    bubble_id  = flush | hazard;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      ret_state <= ST_RUN;
      fcnt      <= '0;
    end else if (freeze_all) begin
      if (state != ST_MEM_WAIT)
        ret_state <= state;
      state <= ST_MEM_WAIT;
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (exe_b && (FLUSH_CYCLES > 1)) begin
            state <= ST_BR_FLUSH;
            fcnt  <= FC_W'(FLUSH_CYCLES - 1);
          end else begin
            state <= ST_RUN;
          end
        end
        ST_BR_FLUSH: begin
          fcnt  <= fcnt - FC_W'(1);
          state <= (fcnt == FC_W'(1)) ? ST_RUN : ST_BR_FLUSH;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_src1       <= '0;
      exe_src2       <= '0;
      exe_src1_valid <= 1'b0;
      exe_src2_valid <= 1'b0;
    end else if (!freeze_all) begin
      if (bubble_id) begin
        exe_src1_valid <= 1'b0;
        exe_src2_valid <= 1'b0;
      end else begin
        exe_src1       <= id_src1;
        exe_src2       <= id_src2;
        exe_src1_valid <= id_uses_rn;
        exe_src2_valid <= id_two_src;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (freeze_all) begin
      if (wait_cnt != WC_W'(MEM_TIMEOUT))
        wait_cnt <= wait_cnt + WC_W'(1);
      if (wait_cnt == WC_W'(MEM_TIMEOUT - 1))
        mem_timeout <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if ((stall_id | freeze_all) && !(&stall_cycles))
      stall_cycles <= stall_cycles + CNT_W'(1);
  end

  fwd_select u_fwd_src1 (
    .forward_en (forward_en),
    .src        (exe_src1),
    .src_valid  (exe_src1_valid),
    .mem_dst    (mem_dst),
    .mem_wb_en  (mem_wb_en),
    .wb_dst     (wb_dst),
    .wb_wb_en   (wb_wb_en),
    .sel        (sel_src1)
  );

  fwd_select u_fwd_src2 (
    .forward_en (forward_en),
    .src        (exe_src2),
    .src_valid  (exe_src2_valid),
    .mem_dst    (mem_dst),
    .mem_wb_en  (mem_wb_en),
    .wb_dst     (wb_dst),
    .wb_wb_en   (wb_wb_en),
    .sel        (sel_src2)
  );

endmodule

// File: tb/tb_hazard_forward_controller.sv
// tb/tb_hazard_forward_controller.sv - directed self-checking bench for hazard_forward_controller
module tb_hazard_forward_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        forward_en;
  logic [3:0]  id_src1, id_src2, exe_dst, mem_dst, wb_dst;
  logic        id_uses_rn, id_two_src, exe_wb_en, exe_mem_read, exe_b;
  logic        mem_wb_en, mem_access, mem_ready, wb_wb_en;
  logic        stall_if, stall_id, flush_if, bubble_id, freeze_all, mem_timeout;
  logic [1:0]  sel_src1, sel_src2;
  logic [15:0] stall_cycles;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hazard_forward_controller #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .forward_en   (forward_en),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .id_uses_rn   (id_uses_rn),
    .id_two_src   (id_two_src),
    .exe_dst      (exe_dst),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_read (exe_mem_read),
    .exe_b        (exe_b),
    .mem_dst      (mem_dst),
    .mem_wb_en    (mem_wb_en),
    .mem_access   (mem_access),
    .mem_ready    (mem_ready),
    .wb_dst       (wb_dst),
    .wb_wb_en     (wb_wb_en),
    .stall_if     (stall_if),
    .stall_id     (stall_id),
    .flush_if     (flush_if),
    .bubble_id    (bubble_id),
    .freeze_all   (freeze_all),
    .sel_src1     (sel_src1),
    .sel_src2     (sel_src2),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    forward_en = 1'b1;
    id_src1 = 4'd0; id_src2 = 4'd0; id_uses_rn = 1'b0; id_two_src = 1'b0;
    exe_dst = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0; exe_b = 1'b0;
    mem_dst = 4'd0; mem_wb_en = 1'b0; mem_access = 1'b0; mem_ready = 1'b0;
    wb_dst = 4'd0; wb_wb_en = 1'b0;
  endtask

  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {stall_if, stall_id, flush_if, bubble_id, freeze_all}, {27'd0, exp});
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    #2;
    check_ctl("reset_ctl", 5'b00000);
    check("reset_sel", {sel_src1, sel_src2}, 4'b0000);
    check("reset_cnt", stall_cycles, 0);
    check("reset_tmo", mem_timeout, 0);
    cyc();
    cyc();
    rst = 1'b1;

    // forwarding priority on a latched src1 = 3
    id_src1 = 4'd3; id_uses_rn = 1'b1;
    cyc();
    mem_dst = 4'd3; mem_wb_en = 1'b1; wb_dst = 4'd3; wb_wb_en = 1'b1;
    #2 check("fwd_mem", sel_src1, 2'b01);
    check("fwd_src2_invalid", sel_src2, 2'b00);
    mem_wb_en = 1'b0;
    #1 check("fwd_wb", sel_src1, 2'b10);
    wb_wb_en = 1'b0;
    #1 check("fwd_none", sel_src1, 2'b00);

    // load-use on src2 = 5
    cyc();
    clear_inputs();
    exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dst = 4'd5;
    id_src2 = 4'd5; id_two_src = 1'b1;
    #2 check_ctl("loaduse_stall", 5'b11010);
    cyc();
    exe_mem_read = 1'b0; exe_wb_en = 1'b0; mem_dst = 4'd5; mem_wb_en = 1'b1;
    #2 check_ctl("loaduse_release", 5'b00000);
    check("loaduse_bubbled_sel", sel_src2, 2'b00);
    cyc();
    #2 check("loaduse_fwd_mem", sel_src2, 2'b01);
    check("loaduse_cnt", stall_cycles, 1);

    // no forwarding: MEM match stalls, select stays at register file
    clear_inputs();
    forward_en = 1'b0;
    id_src1 = 4'd2; id_uses_rn = 1'b1; mem_dst = 4'd2; mem_wb_en = 1'b1;
    #2 check_ctl("nofwd_stall", 5'b11010);
    check("nofwd_sel_a", sel_src1, 2'b00);
    cyc();
    mem_wb_en = 1'b0; wb_dst = 4'd2; wb_wb_en = 1'b1;
    #2 check_ctl("nofwd_release", 5'b00000);
    cyc();
    #2 check("nofwd_sel_b", sel_src1, 2'b00);
    check("nofwd_cnt", stall_cycles, 2);

    // branch with a coincident load-use hazard: two flush cycles, no stall
    clear_inputs();
    exe_mem_read = 1'b1; exe_wb_en = 1'b1; exe_dst = 4'd7;
    id_src1 = 4'd7; id_uses_rn = 1'b1; exe_b = 1'b1;
    #2 check_ctl("br_flush1", 5'b00110);
    cyc();
    exe_b = 1'b0;
    #2 check_ctl("br_flush2", 5'b00110);
    cyc();
    #2 check_ctl("br_back_to_run", 5'b11010);
    clear_inputs();
    #1 check("br_cnt", stall_cycles, 2);

    // async reset while in BR_FLUSH
    cyc();
    exe_b = 1'b1;
    cyc();
    exe_b = 1'b0;
    #2 check("rst_brf_pre", flush_if, 1);
    rst = 1'b0;
    #1 check("rst_brf_flush", flush_if, 0);
    check("rst_brf_cnt", stall_cycles, 0);
    rst = 1'b1;

    // memory wait with a branch pending in EXE
    cyc();
    mem_access = 1'b1; mem_ready = 1'b0; exe_b = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #2 check_ctl($sformatf("wait_ctl_%0d", k), 5'b11001);
      check($sformatf("wait_tmo_%0d", k), mem_timeout, (k == 5) ? 1 : 0);
      cyc();
    end
    mem_ready = 1'b1;
    #2 check_ctl("wait_release_flush", 5'b00110);
    check("wait_cnt5", stall_cycles, 5);
    check("wait_tmo_sticky", mem_timeout, 1);
    cyc();
    mem_access = 1'b0; exe_b = 1'b0;
    #2 check("wait_flush2", flush_if, 1);

    // freeze in BR_FLUSH keeps the remaining flush cycle for after release
    mem_access = 1'b1; mem_ready = 1'b0;
    #1 check_ctl("brf_freeze", 5'b11001);
    cyc();
    cyc();
    #2 check("brf_freeze_cnt", stall_cycles, 7);
    mem_ready = 1'b1;
    #1 check_ctl("brf_resume", 5'b00110);

    // async reset while in MEM_WAIT
    mem_ready = 1'b0;
    #1 rst = 1'b0;
    #1 check("rst_mw_cnt", stall_cycles, 0);
    check("rst_mw_tmo", mem_timeout, 0);
    mem_access = 1'b0;
    #1 check_ctl("rst_mw_ctl", 5'b00000);
    check("rst_mw_sel", {sel_src1, sel_src2}, 4'b0000);
    rst = 1'b1;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
